// File: rtl/video_frame_sync_ctrl.sv
// Camera-to-display frame sync sequencer: aligns the timing generator to camera VS,
// resets and prefills the line FIFO, then releases display timing and watches for underflow.
module video_frame_sync_ctrl #(
    parameter int CNT_W              = 12,
    parameter int FILL_THRESH        = 800,
    parameter int RST_CYCLES         = 8,
    parameter int TIMEOUT_CYCLES     = 1048575,
    parameter int RESYNC_EVERY_FRAME = 0
) (
    input  logic             video_clk,
    input  logic             video_rst_n,
    input  logic             cam_vs,
    input  logic [CNT_W-1:0] fifo_rd_cnt,
    input  logic             fifo_empty,
    input  logic             timing_de,
    output logic             fifo_rst,
    output logic             timing_rst_n,
    output logic             locked,
    output logic             underflow,
    output logic [15:0]      underflow_cnt,
    output logic             timeout_err,
    output logic [2:0]       state_o
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FIFO_RST  = 3'd1,
        ST_WAIT_FILL = 3'd2,
        ST_RUN       = 3'd3,
        ST_RESYNC    = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] FILL_LVL     = FILL_THRESH[CNT_W-1:0];
    localparam logic [19:0]      RST_LAST     = 20'(RST_CYCLES - 1);
    localparam logic [19:0]      TIMEOUT_LAST = 20'(TIMEOUT_CYCLES - 1);
    localparam logic             RESYNC_EN    = (RESYNC_EVERY_FRAME != 0);

    state_t      state_q, state_d;
    logic [19:0] cnt_q, cnt_d;
    logic        vs_sync1_q, vs_sync2_q, vs_sync3_q;
    logic        fifo_rst_q, timing_rst_n_q, locked_q, underflow_q, timeout_err_q;
    logic [15:0] underflow_cnt_q;
    logic        vs_rise_s, uf_s, fill_ok_s, timeout_set_s;

    assign vs_rise_s = vs_sync2_q & ~vs_sync3_q;
    assign uf_s      = timing_de & fifo_empty & (state_q == ST_RUN);
    assign fill_ok_s = (fifo_rd_cnt >= FILL_LVL);

    // Next-state and phase-counter logic of the sync sequencer
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        timeout_set_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (vs_rise_s) begin
                    state_d = ST_FIFO_RST;
                    cnt_d   = 20'd0;
                end else begin
                    cnt_d = 20'd0;
                end
            end
            ST_FIFO_RST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = ST_WAIT_FILL;
                    cnt_d   = 20'd0;
                end else begin
                    cnt_d = cnt_q + 20'd1;
                end
            end
            ST_WAIT_FILL: begin
                // Reaching the fill level wins over a coincident timeout
                if (fill_ok_s) begin
                    state_d = ST_RUN;
                    cnt_d   = 20'd0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d       = ST_IDLE;
                    cnt_d         = 20'd0;
                    timeout_set_s = 1'b1;
                end else begin
                    cnt_d = cnt_q + 20'd1;
                end
            end
            ST_RUN: begin
                if (uf_s) begin
                    state_d = ST_RESYNC;
                end else if (RESYNC_EN && vs_rise_s) begin
                    state_d = ST_FIFO_RST;
                    cnt_d   = 20'd0;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RESYNC: begin
                if (vs_rise_s) begin
                    state_d = ST_FIFO_RST;
                    cnt_d   = 20'd0;
                end else begin
                    state_d = ST_RESYNC;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 20'd0;
            end
        endcase
    end

    // State register, VS synchroniser and registered outputs
    always_ff @(posedge video_clk or negedge video_rst_n) begin
        if (!video_rst_n) begin
            state_q         <= ST_IDLE;
            cnt_q           <= 20'd0;
            vs_sync1_q      <= 1'b0;
            vs_sync2_q      <= 1'b0;
            vs_sync3_q      <= 1'b0;
            fifo_rst_q      <= 1'b0;
            timing_rst_n_q  <= 1'b0;
            locked_q        <= 1'b0;
            underflow_q     <= 1'b0;
            underflow_cnt_q <= 16'd0;
            timeout_err_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            vs_sync1_q     <= cam_vs;
            vs_sync2_q     <= vs_sync1_q;
            vs_sync3_q     <= vs_sync2_q;
            fifo_rst_q     <= (state_d == ST_FIFO_RST);
            // Release only after a full cycle in RUN; drop together with leaving RUN
            timing_rst_n_q <= (state_q == ST_RUN) && (state_d == ST_RUN);
            locked_q       <= (state_q == ST_RUN) && (state_d == ST_RUN);
            underflow_q    <= uf_s;
            if (uf_s && (underflow_cnt_q != 16'hFFFF)) begin
                underflow_cnt_q <= underflow_cnt_q + 16'd1;
            end else begin
                underflow_cnt_q <= underflow_cnt_q;
            end
            timeout_err_q  <= timeout_err_q | timeout_set_s;
        end
    end

    assign fifo_rst      = fifo_rst_q;
    assign timing_rst_n  = timing_rst_n_q;
    assign locked        = locked_q;
    assign underflow     = underflow_q;
    assign underflow_cnt = underflow_cnt_q;
    assign timeout_err   = timeout_err_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_video_frame_sync_ctrl.sv
// Randomised frame-level stimulus for two sequencer instances (per-frame resync off/on),
// each compared every cycle against a duration-based reference model.
module tb_video_frame_sync_ctrl;

    localparam int THRESH  = 800;
    localparam int RSTC    = 8;
    localparam int TMO     = 1000;
    localparam int P_IDLE = 0, P_FRST = 1, P_WAIT = 2, P_RUN = 3, P_RESYNC = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cam_vs;
    logic [11:0] rd_cnt;
    logic        empty;
    logic        de;

    logic        frst0, trn0, lck0, uf0, terr0, frst1, trn1, lck1, uf1, terr1;
    logic [15:0] ucnt0, ucnt1;
    logic [2:0]  st0, st1;

    int n_checks = 0;
    int n_err    = 0;

    // reference model state, one slot per instance
    int md[2], tk[2], exp_ucnt[2];
    bit exp_frst[2], exp_on[2], exp_uf[2], exp_terr[2];
    bit vs_hist[3];
    bit resync_en[2];

    always #5 clk = ~clk;

    video_frame_sync_ctrl #(.CNT_W(12), .FILL_THRESH(THRESH), .RST_CYCLES(RSTC),
        .TIMEOUT_CYCLES(TMO), .RESYNC_EVERY_FRAME(0)) dut0 (
        .video_clk(clk), .video_rst_n(rst_n), .cam_vs(cam_vs), .fifo_rd_cnt(rd_cnt),
        .fifo_empty(empty), .timing_de(de), .fifo_rst(frst0), .timing_rst_n(trn0),
        .locked(lck0), .underflow(uf0), .underflow_cnt(ucnt0), .timeout_err(terr0),
        .state_o(st0));

    video_frame_sync_ctrl #(.CNT_W(12), .FILL_THRESH(THRESH), .RST_CYCLES(RSTC),
        .TIMEOUT_CYCLES(TMO), .RESYNC_EVERY_FRAME(1)) dut1 (
        .video_clk(clk), .video_rst_n(rst_n), .cam_vs(cam_vs), .fifo_rd_cnt(rd_cnt),
        .fifo_empty(empty), .timing_de(de), .fifo_rst(frst1), .timing_rst_n(trn1),
        .locked(lck1), .underflow(uf1), .underflow_cnt(ucnt1), .timeout_err(terr1),
        .state_o(st1));

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            md[k] = P_IDLE; tk[k] = 0; exp_ucnt[k] = 0;
            exp_frst[k] = 1'b0; exp_on[k] = 1'b0; exp_uf[k] = 1'b0; exp_terr[k] = 1'b0;
        end
        for (int i = 0; i < 3; i++) vs_hist[i] = 1'b0;
    endtask

    // One clock edge of behaviour: phases are tracked by elapsed cycle counts.
    task automatic model_step();
        bit rise, uf;
        int nx;
        rise = vs_hist[1] && !vs_hist[2];
        vs_hist[2] = vs_hist[1];
        vs_hist[1] = vs_hist[0];
        vs_hist[0] = cam_vs;
        for (int k = 0; k < 2; k++) begin
            uf = de && empty && (md[k] == P_RUN);
            nx = md[k];
            if (md[k] == P_IDLE) begin
                if (rise) begin nx = P_FRST; tk[k] = 0; end
            end else if (md[k] == P_FRST) begin
                tk[k]++;
                if (tk[k] == RSTC) begin nx = P_WAIT; tk[k] = 0; end
            end else if (md[k] == P_WAIT) begin
                if (int'(rd_cnt) >= THRESH) nx = P_RUN;
                else begin
                    tk[k]++;
                    if (tk[k] == TMO) begin nx = P_IDLE; exp_terr[k] = 1'b1; end
                end
            end else if (md[k] == P_RUN) begin
                if (uf) nx = P_RESYNC;
                else if (resync_en[k] && rise) begin nx = P_FRST; tk[k] = 0; end
            end else begin
                if (rise) begin nx = P_FRST; tk[k] = 0; end
            end
            exp_on[k]   = (md[k] == P_RUN) && (nx == P_RUN);
            exp_frst[k] = (nx == P_FRST);
            exp_uf[k]   = uf;
            if (uf && exp_ucnt[k] < 65535) exp_ucnt[k]++;
            md[k] = nx;
        end
    endtask

    task automatic check_all();
        check_val("k0 state", {29'd0, st0}, md[0]);
        check_val("k0 fifo_rst", {31'd0, frst0}, {31'd0, exp_frst[0]});
        check_val("k0 timing_rst_n", {31'd0, trn0}, {31'd0, exp_on[0]});
        check_val("k0 locked", {31'd0, lck0}, {31'd0, exp_on[0]});
        check_val("k0 underflow", {31'd0, uf0}, {31'd0, exp_uf[0]});
        check_val("k0 underflow_cnt", {16'd0, ucnt0}, exp_ucnt[0]);
        check_val("k0 timeout_err", {31'd0, terr0}, {31'd0, exp_terr[0]});
        check_val("k1 state", {29'd0, st1}, md[1]);
        check_val("k1 fifo_rst", {31'd0, frst1}, {31'd0, exp_frst[1]});
        check_val("k1 timing_rst_n", {31'd0, trn1}, {31'd0, exp_on[1]});
        check_val("k1 locked", {31'd0, lck1}, {31'd0, exp_on[1]});
        check_val("k1 underflow", {31'd0, uf1}, {31'd0, exp_uf[1]});
        check_val("k1 underflow_cnt", {16'd0, ucnt1}, exp_ucnt[1]);
        check_val("k1 timeout_err", {31'd0, terr1}, {31'd0, exp_terr[1]});
    endtask

    task automatic cycle();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        int mode, period;
        bit found;
        resync_en[0] = 1'b0;
        resync_en[1] = 1'b1;
        rst_n = 1'b0; cam_vs = 1'b0; rd_cnt = 12'd0; empty = 1'b0; de = 1'b0;
        model_reset();
        repeat (3) cycle();
        rst_n = 1'b1;

        for (int f = 0; f < 20; f++) begin
            // lock, underflow, timeout, re-lock; then random frame types
            if (f == 0 || f == 3) mode = 0;
            else if (f == 1) mode = 1;
            else if (f == 2) mode = 2;
            else mode = int'($urandom_range(0, 3));
            period = int'($urandom_range(1300, 1900));
            for (int c = 0; c < period; c++) begin
                cam_vs = (c < 16) || ((f % 3 == 1) && c >= 300 && c < 306) ||
                         ((f % 3 == 2) && c >= 1200 && c < 1206);
                if (mode <= 1) rd_cnt = 12'(c);
                else if (mode == 2) rd_cnt = 12'(100 + $urandom_range(0, 50));
                else rd_cnt = 12'd799;
                if (mode == 1 && c >= 1000 && c < 1003) begin
                    de = 1'b1; empty = 1'b1;
                end else begin
                    de = 1'($urandom_range(0, 1));
                    empty = ($urandom_range(0, 1999) == 0);
                end
                cycle();
            end
        end

        // Reset in the middle of a fifo_rst pulse
        rst_n = 1'b0; cam_vs = 1'b0; de = 1'b0; empty = 1'b0; rd_cnt = 12'd0;
        repeat (2) cycle();
        rst_n = 1'b1;
        repeat (3) cycle();
        cam_vs = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            cycle();
            found = (md[0] == P_FRST) && (tk[0] == 3);
        end
        check_val("reach_pulse_cycle4", {31'd0, found}, 32'd1);
        check_val("pulse_before_reset", {31'd0, frst0}, 32'd1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        repeat (2) cycle();
        rst_n = 1'b1;
        cam_vs = 1'b0;
        repeat (20) cycle();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/video_frame_sync_ctrl.md
Name: video_frame_sync_ctrl

Overview:
Sequences the camera-to-display buffer path in the video_clk domain: aligns the display timing generator to the camera frame, issues the line-FIFO reset, waits for a prefill level, then releases the timing generator. Watches the FIFO read side for underflow and re-locks on the next camera frame. Sits between the camera capture front end, the async video FIFO, and the RGB timing generator.

Parameters:
CNT_W, 12, width of FIFO read-side word count input
FILL_THRESH, 800, words required in FIFO before timing generator is released
RST_CYCLES, 8, video_clk cycles fifo_rst is held high
TIMEOUT_CYCLES, 1048575, max cycles in WAIT_FILL before abort (20-bit counter)
RESYNC_EVERY_FRAME, 0, 1 = re-run the full sequence on every camera VS rising edge

Ports:
video_clk  input  1  video pixel clock; sole clock
video_rst_n  input  1  asynchronous active-low reset
cam_vs  input  1  camera vertical sync, asynchronous to video_clk
fifo_rd_cnt  input  CNT_W  FIFO read-side word count (video_clk domain)
fifo_empty  input  1  FIFO read-side empty flag
timing_de  input  1  data-enable from timing generator (= FIFO RdEn)
fifo_rst  output  1  active-high FIFO reset
timing_rst_n  output  1  active-low timing generator reset
locked  output  1  high while in RUN
underflow  output  1  one-cycle pulse when timing_de=1 and fifo_empty=1
underflow_cnt  output  16  saturating count of underflow pulses
timeout_err  output  1  sticky; set on WAIT_FILL timeout
state_o  output  3  current state encoding

Behaviour:
- Reset (video_rst_n=0): state IDLE, fifo_rst=0, timing_rst_n=0, locked=0, underflow=0, underflow_cnt=0, timeout_err=0, counters 0, sync flops 0.
- cam_vs passes through a 2-flop synchroniser; vs_rise = sync2 & ~sync3 (third flop). Rising-edge detect latency from cam_vs: 3 cycles.
- States (state_o): IDLE=0, FIFO_RST=1, WAIT_FILL=2, RUN=3, RESYNC=4.
- IDLE: timing_rst_n=0, fifo_rst=0. On vs_rise -> FIFO_RST, cycle counter cleared.
- FIFO_RST: fifo_rst=1 for exactly RST_CYCLES cycles, then -> WAIT_FILL with counter cleared; fifo_rst low on the transition cycle.
- WAIT_FILL: timing_rst_n=0. If fifo_rd_cnt >= FILL_THRESH (unsigned compare) -> RUN. Else if counter == TIMEOUT_CYCLES-1 -> IDLE, timeout_err<=1. Fill check has priority over timeout on the same cycle.
- RUN: timing_rst_n=1, locked=1 (both registered, asserted the cycle after entry). On underflow -> RESYNC. If RESYNC_EVERY_FRAME=1 and vs_rise -> FIFO_RST. Underflow has priority over vs_rise.
- RESYNC: timing_rst_n=0, locked=0; waits for vs_rise -> FIFO_RST.
- underflow: registered, = timing_de & fifo_empty & (state==RUN); one pulse per cycle the condition holds. underflow_cnt increments on each pulse and saturates at 16'hFFFF; cleared only by reset.
- timeout_err cleared only by reset; it does not block a subsequent IDLE->FIFO_RST sequence.
- vs_rise in FIFO_RST or WAIT_FILL is ignored (no restart).
- All outputs registered; no combinational paths from inputs to outputs.
- Reset asserted mid-sequence: immediate return to reset values, including fifo_rst=0 even if it was mid-pulse.

Test Plan:
- Release reset, toggle cam_vs high at t0 -> fifo_rst high for exactly 8 cycles starting 4 cycles after t0; state_o 0->1->2.
- In WAIT_FILL ramp fifo_rd_cnt 0..800 -> timing_rst_n and locked rise one cycle after fifo_rd_cnt reaches 800; state_o=3.
- In RUN drive timing_de=1 with fifo_empty=1 for 3 cycles -> single-cycle underflow pulse, underflow_cnt=1, state RESYNC, timing_rst_n=0; next cam_vs rise restarts FIFO_RST.
- Hold fifo_rd_cnt=100 with TIMEOUT_CYCLES=1000 -> after 1000 WAIT_FILL cycles state IDLE, timeout_err=1 and stays 1 through next successful lock.
- RESYNC_EVERY_FRAME=1, locked, second cam_vs rise -> locked drops, fifo_rst 8-cycle pulse, re-lock after refill; with parameter 0 the same edge leaves locked=1.
- Assert video_rst_n low during fifo_rst pulse (cycle 4 of 8) -> fifo_rst, timing_rst_n, locked all 0 immediately; state_o=0.
